dpram_burst_reader: RTL

//   Read-side sequencer for the dpram sample buffer. It runs in the RAM read-clock domain.
//   On a start command it reads len words from base_addr upward, with wrap-around.
//   It absorbs the RAM's 1-cycle registered read latency and presents the words as a valid/ready stream.
//   The stream feeds downstream DSP/USB framing logic.

---
 rtl/dpram_burst_reader.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/dpram_burst_reader.sv
// Read-side burst sequencer for the dpram sample buffer: issues wrapping reads,
// absorbs the 1-cycle registered RAM latency and streams words out as valid/ready.
module dpram_burst_reader #(
    parameter int ASZ = 10,
    parameter int DSZ = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [ASZ-1:0] base_addr,
    input  logic [ASZ:0]   len,
    output logic [ASZ-1:0] rd_addr,
    input  logic [DSZ-1:0] rd_data,
    output logic [DSZ-1:0] m_data,
    output logic           m_valid,
    input  logic           m_ready,
    output logic           m_last,
    output logic           busy,
    output logic           done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ASZ:0]   REM_ONE  = {{ASZ{1'b0}}, 1'b1};
    localparam logic [ASZ:0]   REM_ZERO = {(ASZ+1){1'b0}};
    localparam logic [ASZ-1:0] ADDR_ONE = {{(ASZ-1){1'b0}}, 1'b1};

    state_t         state_q, state_d;
    logic [ASZ-1:0] rd_addr_q, rd_addr_d;
    logic [ASZ:0]   remaining_q, remaining_d;
    logic           infl_q, infl_d;
    logic           infl_last_q, infl_last_d;
    logic [1:0]     occ_q, occ_d;
    logic [DSZ-1:0] head_data_q, head_data_d;
    logic           head_last_q, head_last_d;
    logic [DSZ-1:0] tail_data_q, tail_data_d;
    logic           tail_last_q, tail_last_d;
    logic           m_valid_q, m_valid_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           pop_s;
    logic           push_s;
    logic           issue_s;
    logic [2:0]     level_s;

    // Next-state logic: read issue, skid-buffer update, FSM and registered outputs.
    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        remaining_d = remaining_q;
        occ_d       = occ_q;
        head_data_d = head_data_q;
        head_last_d = head_last_q;
        tail_data_d = tail_data_q;
        tail_last_d = tail_last_q;

        pop_s   = m_valid_q & m_ready;
        push_s  = infl_q;
        // Entries that will be held once this cycle's pop and the in-flight read settle.
        level_s = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop_s};
        issue_s = (state_q == S_RUN) && (level_s < 3'd2);

        infl_d      = issue_s;
        infl_last_d = issue_s && (remaining_q == REM_ONE);

        if (issue_s) begin
            rd_addr_d   = rd_addr_q + ADDR_ONE;
            remaining_d = remaining_q - REM_ONE;
        end else begin
            rd_addr_d   = rd_addr_q;
            remaining_d = remaining_q;
        end

        // The head entry is the output register, so it only moves on pop or fill-from-empty.
        case (occ_q)
            2'd0: begin
                if (push_s) begin
                    head_data_d = rd_data;
                    head_last_d = infl_last_q;
                    occ_d       = 2'd1;
                end else begin
                    occ_d = 2'd0;
                end
            end
            2'd1: begin
                case ({push_s, pop_s})
                    2'b11: begin
                        head_data_d = rd_data;
                        head_last_d = infl_last_q;
                    end
                    2'b10: begin
                        tail_data_d = rd_data;
                        tail_last_d = infl_last_q;
                        occ_d       = 2'd2;
                    end
                    2'b01:   occ_d = 2'd0;
                    default: occ_d = 2'd1;
                endcase
            end
            2'd2: begin
                case ({push_s, pop_s})
                    2'b11: begin
                        head_data_d = tail_data_q;
                        head_last_d = tail_last_q;
                        tail_data_d = rd_data;
                        tail_last_d = infl_last_q;
                    end
                    2'b01: begin
                        head_data_d = tail_data_q;
                        head_last_d = tail_last_q;
                        occ_d       = 2'd1;
                    end
                    default: occ_d = 2'd2;
                endcase
            end
            default: occ_d = 2'd0;
        endcase

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rd_addr_d   = base_addr;
                    remaining_d = len;
                    state_d     = (len == REM_ZERO) ? S_DONE : S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (issue_s && (remaining_q == REM_ONE)) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                // Looking at occ_d lets done follow the final handshake by one cycle.
                if (!infl_q && (occ_d == 2'd0)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        m_valid_d = (occ_d != 2'd0);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rd_addr_q   <= {ASZ{1'b0}};
            remaining_q <= {(ASZ+1){1'b0}};
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            occ_q       <= 2'd0;
            head_data_q <= {DSZ{1'b0}};
            head_last_q <= 1'b0;
            tail_data_q <= {DSZ{1'b0}};
            tail_last_q <= 1'b0;
            m_valid_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            remaining_q <= remaining_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
            occ_q       <= occ_d;
            head_data_q <= head_data_d;
            head_last_q <= head_last_d;
            tail_data_q <= tail_data_d;
            tail_last_q <= tail_last_d;
            m_valid_q   <= m_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rd_addr = rd_addr_q;
    assign m_data  = head_data_q;
    assign m_last  = head_last_q;
    assign m_valid = m_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

    skid_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_s && !pop_s && (occ_q == 2'd2)));

endmodule
